// File: rtl/button_release_debounce.sv
// Synchronizes and debounces a raw push-button, emitting press/release strobes and a clean level.
// Optional long-press strobe under BUTTON_LONG_PRESS_EN. Strobe lags input by DEBOUNCE_CYCLES+2 edges; no backpressure.
module button_release_debounce #(
`ifdef BUTTON_LONG_PRESS_EN
  parameter int LONG_CYCLES = 40,
`endif
  parameter int DEBOUNCE_CYCLES = 10,
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic btnIn,
  output logic pressed,
  output logic bPress,
  output logic bRelease
`ifdef BUTTON_LONG_PRESS_EN
  ,
  output logic longPress
`endif
);

  typedef enum logic [1:0] {IDLE, PRESS_CHK, HELD, REL_CHK} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  logic             sync1;
  logic             sync2;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      state    <= IDLE;
      cnt      <= '0;
      pressed  <= 1'b0;
      bPress   <= 1'b0;
      bRelease <= 1'b0;
    end else begin
      sync1    <= btnIn;
      sync2    <= sync1;
      bPress   <= 1'b0;
      bRelease <= 1'b0;
      case (state)
        IDLE: begin
          if (sync2) begin
            state <= PRESS_CHK;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= '0;
          end
        end
        PRESS_CHK: begin
          if (!sync2) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state   <= HELD;
            cnt     <= '0;
            bPress  <= 1'b1;
            pressed <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        HELD: begin
          if (!sync2) begin
            state <= REL_CHK;
            cnt   <= CNT_ONE;
          end
        end
        REL_CHK: begin
          // A bounce back high returns to HELD; pressed never dropped so no strobe is owed.
          if (sync2) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            bRelease <= 1'b1;
            pressed  <= 1'b0;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
      endcase
    end
  end

`ifdef BUTTON_LONG_PRESS_EN
  localparam int HOLD_W = $clog2(LONG_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

  logic [HOLD_W-1:0] holdCnt;
  logic              holding;

  assign holding = (state == HELD) || (state == REL_CHK);

  // Cleared while not holding, so it is zero on entry to HELD; REL_CHK bounces keep the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      holdCnt   <= '0;
      longPress <= 1'b0;
    end else begin
      longPress <= holding && (holdCnt == HOLD_LAST);
      if (!holding) begin
        holdCnt <= '0;
      end else if (holdCnt != HOLD_MAX) begin
        holdCnt <= holdCnt + HOLD_W'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_button_release_debounce.sv
// Directed bench for button_release_debounce; long-press checks build only with BUTTON_LONG_PRESS_EN.
module tb_button_release_debounce;

  logic clk;
  logic rst;
  logic btnIn;
  logic pressed;
  logic bPress;
  logic bRelease;
  logic longPress;

  int nChecks = 0;
  int nPass   = 0;
  int cyc     = 0;
  int mark    = 0;

  int nPress, nRel, nBoth, nLong;
  int pressAt, relAt, longAt;

  button_release_debounce dut (
    .clk      (clk),
    .rst      (rst),
    .btnIn    (btnIn),
    .pressed  (pressed),
    .bPress   (bPress),
    .bRelease (bRelease)
`ifdef BUTTON_LONG_PRESS_EN
    ,
    .longPress(longPress)
`endif
  );

`ifndef BUTTON_LONG_PRESS_EN
  assign longPress = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input int got, input int exp);
    nChecks++;
    if (got == exp) nPass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic clrMon();
    nPress = 0; nRel = 0; nBoth = 0; nLong = 0;
    pressAt = -1; relAt = -1; longAt = -1;
  endtask

  // Advance one edge and sample outputs just after it.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (bPress === 1'b1) begin nPress++; pressAt = cyc; end
    if (bRelease === 1'b1) begin nRel++; relAt = cyc; end
    if (bPress === 1'b1 && bRelease === 1'b1) nBoth++;
    if (longPress === 1'b1) begin nLong++; longAt = cyc; end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    clrMon();
    rst   = 1'b1;
    btnIn = 1'b1;

    // Reset held with button pressed
    tick();
    checkVal("rst_pressed", int'(pressed), 0);
    checkVal("rst_bPress", int'(bPress), 0);
    run(2);
    checkVal("rst_bRelease", int'(bRelease), 0);
    checkVal("rst_longPress", int'(longPress), 0);
    checkVal("rst_pressed_end", int'(pressed), 0);

    // Held through reset deassert: fresh press
    rst = 1'b0;
    mark = cyc;
    clrMon();
    run(20);
    checkVal("rstrel_nPress", nPress, 1);
    checkVal("rstrel_latency", pressAt - mark, 12);
    checkVal("rstrel_pressed", int'(pressed), 1);

    // Hold 30 cycles then clean release
    clrMon();
    run(30);
    checkVal("hold_noStrobe", nPress + nRel, 0);
    checkVal("hold_pressed", int'(pressed), 1);
    btnIn = 1'b0;
    mark = cyc;
    clrMon();
    run(20);
    checkVal("rel_nRelease", nRel, 1);
    checkVal("rel_latency", relAt - mark, 12);
    checkVal("rel_pressed", int'(pressed), 0);
    checkVal("rel_noPress", nPress, 0);

    // Bouncy press: 3 high / 2 low x4
    clrMon();
    for (int k = 0; k < 4; k++) begin
      btnIn = 1'b1; run(3);
      btnIn = 1'b0; run(2);
    end
    checkVal("bounce_noStrobe", nPress + nRel, 0);
    checkVal("bounce_pressed", int'(pressed), 0);
    btnIn = 1'b1;
    mark = cyc;
    clrMon();
    run(20);
    checkVal("bounce_nPress", nPress, 1);
    checkVal("bounce_latency", pressAt - mark, 12);
    checkVal("bounce_both", nBoth, 0);

    // 5-cycle low glitch while HELD
    run(10);
    clrMon();
    btnIn = 1'b0; run(5);
    btnIn = 1'b1; run(30);
    checkVal("glitch_noRelease", nRel, 0);
    checkVal("glitch_noPress", nPress, 0);
    checkVal("glitch_pressed", int'(pressed), 1);

    // Reset at REL_CHK count 6 aborts release
    btnIn = 1'b0;
    clrMon();
    run(8);
    checkVal("relchk_pressed", int'(pressed), 1);
    rst = 1'b1;
    tick();
    checkVal("abort_pressed", int'(pressed), 0);
    checkVal("abort_bRelease", int'(bRelease), 0);
    rst = 1'b0;
    run(20);
    checkVal("abort_noStrobe", nPress + nRel, 0);
    checkVal("abort_pressedIdle", int'(pressed), 0);

`ifdef BUTTON_LONG_PRESS_EN
    // Long press: hold 100 cycles past bPress
    btnIn = 1'b1;
    mark = cyc;
    clrMon();
    run(112);
    checkVal("long_pressLatency", pressAt - mark, 12);
    checkVal("long_nLong", nLong, 1);
    checkVal("long_offset", longAt - pressAt, 40);
    btnIn = 1'b0;
    mark = cyc;
    run(20);
    checkVal("long_nRelease", nRel, 1);
    checkVal("long_relLatency", relAt - mark, 12);
    checkVal("long_single", nLong, 1);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

// File: doc/button_release_debounce.md
Name: button_release_debounce

Overview:
- Sits directly upstream of the burst generator and drives its bRelease input.
- Takes the raw asynchronous push-button level, synchronizes it, debounces it with a consecutive-sample counter and tracks press/release in an FSM.
- Emits clean single-cycle press and release strobes plus a debounced level.
- The burst generator starts its clock burst on the bRelease strobe.

Parameters:
- DEBOUNCE_CYCLES, 10, consecutive stable synchronized samples required to accept a level change. Legal range >= 2. Silicon builds override with the board value, e.g. 500000 at 50 MHz.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), debounce counter width. Derived; never overridden.
- LONG_CYCLES, 40, cycles of debounced hold before longPress fires. Used only with LONG_PRESS_EN.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- btnIn  in  1  raw button level, asynchronous, 1 = pressed, bouncy.
- pressed  out  1  debounced button level.
- bPress  out  1  one-cycle strobe on accepted press.
- bRelease  out  1  one-cycle strobe on accepted release; feeds burst generator.
- longPress  out  1  present only with LONG_PRESS_EN.

Behaviour:
- Clocking and reset:
  - One clock domain, clk.
  - rst is synchronous and active-high, sampled on the rising edge of clk.
  - While rst = 1: sync FFs = 0, state = IDLE, counters = 0; pressed, bPress, bRelease, longPress = 0.
- Synchronizer:
  - Two-flop chain, sync1 then sync2.
  - Only sync2 is used by the rest of the logic.
- FSM states: IDLE, PRESS_CHK, HELD, REL_CHK.
  - IDLE: sync2 = 1 -> PRESS_CHK with cnt = 1. Otherwise stay, cnt = 0.
  - PRESS_CHK:
    - sync2 = 0 -> IDLE with cnt = 0 (bounce rejected, no strobe).
    - sync2 = 1 and cnt == DEBOUNCE_CYCLES-1 -> HELD.
    - Otherwise cnt += 1.
  - HELD: sync2 = 0 -> REL_CHK with cnt = 1. Otherwise stay.
  - REL_CHK:
    - sync2 = 1 -> HELD with cnt = 0 (bounce rejected).
    - sync2 = 0 and cnt == DEBOUNCE_CYCLES-1 -> IDLE.
    - Otherwise cnt += 1.
- Outputs:
  - All outputs are registered.
  - bPress = 1 for exactly the one cycle after the PRESS_CHK -> HELD edge.
  - bRelease = 1 for exactly the one cycle after the REL_CHK -> IDLE edge.
  - pressed = 1 while state is HELD or REL_CHK.
  - pressed rises in the same cycle bPress is high and falls in the same cycle bRelease is high.
- Latency: if btnIn changes and stays stable from clock edge E0, the strobe is high in the cycle starting at edge E0 + DEBOUNCE_CYCLES + 2. With the default of 10, that is the cycle starting at edge E0 + 12.
- Boundary conditions:
  - bPress and bRelease are never high in the same cycle.
  - Strobes are never issued back-to-back; a minimum of DEBOUNCE_CYCLES cycles separates them.
  - Glitch shorter than DEBOUNCE_CYCLES synchronized samples: fully ignored, counter cleared.
  - Counter saturates by construction; it never wraps.
  - rst asserted mid-check or while HELD: aborts with no strobe.
  - Button held through rst deassert: treated as a fresh press and debounced normally; bPress follows.

Optional Feature:
- Macro: BUTTON_LONG_PRESS_EN.
- Defined:
  - A hold counter runs while in HELD and REL_CHK.
  - It clears on entering HELD from PRESS_CHK.
  - It is not cleared by a rejected REL_CHK bounce.
  - It saturates at LONG_CYCLES.
  - longPress = 1 for one cycle when the hold counter reaches LONG_CYCLES, at most once per press.
  - bRelease is still issued normally.
- Undefined: longPress port, hold counter and LONG_CYCLES logic are absent; behaviour is otherwise identical.

Test Plan:
- rst = 1 for 3 cycles with btnIn = 1, then rst = 0 -> all outputs 0 during reset; bPress high exactly at edge 12 after deassert; pressed = 1 from then on.
- Clean press, hold 30 cycles, clean release (DEBOUNCE_CYCLES = 10) -> one bPress, then one bRelease 12 cycles after btnIn falls, each 1 cycle wide; pressed low after bRelease.
- Bouncy press: pulses of 3 high / 2 low x4, then steady high -> no strobe during bounce; single bPress 12 cycles after the last rising edge.
- While HELD, 5-cycle low glitch on btnIn -> no bRelease, pressed stays 1.
- rst pulsed at count 6 of REL_CHK -> no bRelease; outputs 0 one cycle after the rst edge.
- BUTTON_LONG_PRESS_EN, LONG_CYCLES = 40, hold 100 cycles -> exactly one longPress 40 cycles after bPress; bRelease still issued on release.
